led_blink_arbiter: RTL

Shares the single red status LED between several requesters. Each requester asks for a blink code, a count of flashes, and the block grants requesters in round-robin order. It then plays the code on `LED_RED` using a millisecond time base derived from `CLK`, and signals completion with a one-cycle `DONE` pulse. It sits between the board-level status sources (bootloader, configuration checker, error monitor) and the `LED_RED` pin, replacing the free-running flasher.

---
 rtl/led_blink_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that shares one red status LED between several requesters
// and plays each granted requester's flash-count code on it.
module led_blink_arbiter #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned ON_MS      = 125,
   parameter int unsigned OFF_MS     = 125,
   parameter int unsigned GAP_MS     = 1000
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic [NUM_REQ-1:0]     REQ,
   input  logic [4*NUM_REQ-1:0]   CODE,
   output logic [NUM_REQ-1:0]     GRANT,
   output logic [NUM_REQ-1:0]     DONE,
   output logic                   BUSY,
   output logic                   LED_RED
);

   localparam int unsigned PW      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int unsigned MAX_OO  = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
   localparam int unsigned MAX_MS  = (MAX_OO > GAP_MS) ? MAX_OO : GAP_MS;
   localparam int unsigned MW      = $clog2(MAX_MS + 1);
   localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
   localparam logic [MW-1:0] ON_LAST    = MW'(ON_MS - 1);
   localparam logic [MW-1:0] OFF_LAST   = MW'(OFF_MS - 1);
   localparam logic [MW-1:0] GAP_LAST   = MW'(GAP_MS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [PW-1:0]        r_presc;
   logic [MW-1:0]        r_ms;
   logic [3:0]           r_cnt;
   logic [IW-1:0]        r_last;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   r_done;
   logic                 r_busy;
   logic                 r_led;

   state_t               w_state_nxt;
   logic [PW-1:0]        w_presc_nxt;
   logic [MW-1:0]        w_ms_nxt;
   logic [3:0]           w_cnt_nxt;
   logic [IW-1:0]        w_last_nxt;
   logic [NUM_REQ-1:0]   w_grant_nxt;
   logic [NUM_REQ-1:0]   w_done_nxt;

   logic                 w_tick;
   logic                 w_phase_end;
   logic [MW-1:0]        w_phase_last;
   logic                 w_found;
   logic [IW-1:0]        w_pick;
   logic [IW-1:0]        w_j;
   logic [3:0]           w_codes [NUM_REQ];
   logic [3:0]           w_code;

   // Per-requester view of the packed code bus
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_codes[i] = CODE[4*i +: 4];
      end
   end

   assign w_code = w_codes[w_pick];

   // Round-robin search from last+1; scanning farthest-first lets the nearest win
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_j     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_j = IW'((32'(r_last) + NUM_REQ - k) % NUM_REQ);
         if (REQ[w_j]) begin
            w_found = 1'b1;
            w_pick  = w_j;
         end
      end
   end

   assign w_tick = (r_presc == PRESC_LAST);

   always_comb begin
      w_phase_last = GAP_LAST;
      case (r_state)
         S_ON:    w_phase_last = ON_LAST;
         S_OFF:   w_phase_last = OFF_LAST;
         default: w_phase_last = GAP_LAST;
      endcase
   end

   assign w_phase_end = w_tick && (r_ms == w_phase_last);

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_ms_nxt    = r_ms;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
      w_grant_nxt = r_grant;
      w_done_nxt  = '0;

      if (r_state != S_IDLE) begin
         w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            w_ms_nxt = w_phase_end ? '0 : r_ms + MW'(1);
         end
      end

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_nxt = NUM_REQ'(1) << w_pick;
               w_last_nxt  = w_pick;
               w_cnt_nxt   = w_code;
               w_presc_nxt = '0;
               w_ms_nxt    = '0;
               w_state_nxt = (w_code != 4'd0) ? S_ON : S_GAP;
            end
         end
         S_ON: begin
            if (w_phase_end) begin
               w_cnt_nxt   = r_cnt - 4'd1;
               w_state_nxt = (r_cnt == 4'd1) ? S_GAP : S_OFF;
            end
         end
         S_OFF: begin
            if (w_phase_end) begin
               w_state_nxt = S_ON;
            end
         end
         S_GAP: begin
            if (w_phase_end) begin
               w_done_nxt  = r_grant;
               w_grant_nxt = '0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; outputs are decoded from the next state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_ms    <= '0;
         r_cnt   <= '0;
         r_last  <= IW'(NUM_REQ - 1);
         r_grant <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
         r_led   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_ms    <= w_ms_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_grant <= w_grant_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_led   <= (w_state_nxt == S_ON);
      end
   end

   assign GRANT   = r_grant;
   assign DONE    = r_done;
   assign BUSY    = r_busy;
   assign LED_RED = r_led;

endmodule
